inst_queue: RTL and testbench

- Decoupling instruction buffer between the IF stage and the dual-issue ID stage.
- Accepts 0–2 fetched instructions per cycle, each with its pc, instruction word, prediction info and fetch exception.
- Presents the two oldest entries on the a/b decode slots.
- Pops them as ID reports via id_consume_inst (0/1/2).
- Cleared by a redirect flush (branch mistake / exception / ertn).

---
 rtl/inst_queue.sv | 152 +++++++++++++++
 tb/tb_inst_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// inst_queue: decoupling instruction buffer between IF and the dual-issue ID stage.
// Circular buffer of DEPTH entries; up to 2 pushes and 2 pops per cycle.
// The two oldest entries are presented combinationally on the a/b decode slots.
// Optional feature macro: IQ_PERF_CNT_EN adds the empty/stall cycle counters.

package iq_pkg;
  typedef logic [5:0] exception_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        have_exc;
    exception_t  exc_type;
  } iq_entry_t;
endpackage

module inst_queue
  import iq_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [1:0]  if_push_num,
  input  logic [31:0] if0_pc,
  input  logic [31:0] if1_pc,
  input  logic [31:0] if0_inst,
  input  logic [31:0] if1_inst,
  input  logic        if0_pred_branch_taken,
  input  logic        if1_pred_branch_taken,
  input  logic [31:0] if0_pred_branch_target,
  input  logic [31:0] if1_pred_branch_target,
  input  logic        if0_have_exception,
  input  logic        if1_have_exception,
  input  exception_t  if0_exception_type,
  input  exception_t  if1_exception_type,
  output logic        iq_ready,
  input  logic [1:0]  id_consume_inst,
  output logic        a_valid,
  output logic [31:0] a_pc,
  output logic [31:0] a_inst,
  output logic        a_pred_branch_taken,
  output logic [31:0] a_pred_branch_target,
  output logic        a_have_exception,
  output exception_t  a_exception_type,
  output logic        b_valid,
  output logic [31:0] b_pc,
  output logic [31:0] b_inst,
  output logic        b_pred_branch_taken,
  output logic [31:0] b_pred_branch_target,
  output logic        b_have_exception,
  output exception_t  b_exception_type
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0] iq_empty_cycles,
  output logic [31:0] iq_stall_cycles
`endif
);

  localparam int NUM_LANES = 2;
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  iq_entry_t                 mem [DEPTH];
  logic [PTR_W-1:0]          head, tail;
  logic [PTR_W:0]            count;
  iq_entry_t [NUM_LANES-1:0] wr_ent;
  iq_entry_t                 rd_a, rd_b;
  logic [1:0]                push_eff, pop_eff;

  assign wr_ent[0] = '{pc: if0_pc, inst: if0_inst, pred_taken: if0_pred_branch_taken,
                       pred_target: if0_pred_branch_target, have_exc: if0_have_exception,
                       exc_type: if0_exception_type};
  assign wr_ent[1] = '{pc: if1_pc, inst: if1_inst, pred_taken: if1_pred_branch_taken,
                       pred_target: if1_pred_branch_target, have_exc: if1_have_exception,
                       exc_type: if1_exception_type};

  // Ready needs two free slots so a full dual push can always land.
  assign iq_ready = (count <= READY_MAX);

  // Effective push/pop: pushes while not ready (or the illegal code 3) are
  // dropped; over-consumption is clamped to what is actually held.
  always_comb begin
    push_eff = 2'd0;
    pop_eff  = id_consume_inst;
    if (iq_ready && if_push_num != 2'd3) push_eff = if_push_num;
    if ({{(PTR_W-1){1'b0}}, id_consume_inst} > count) pop_eff = count[1:0];
  end

  // Pointer/occupancy state; flush outranks push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_eff);
      tail  <= tail + PTR_W'(push_eff);
      count <= count + (PTR_W+1)'(push_eff) - (PTR_W+1)'(pop_eff);
    end
  end

  // Entry storage: lane l writes at tail+l; flush leaves contents in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (l < int'(push_eff)) mem[tail + PTR_W'(l)] <= wr_ent[l];
    end
  end

  assign rd_a = mem[head];
  assign rd_b = mem[head + PTR_W'(1)];

  assign a_valid              = (count != '0);
  assign a_pc                 = rd_a.pc;
  assign a_inst               = rd_a.inst;
  assign a_pred_branch_taken  = rd_a.pred_taken;
  assign a_pred_branch_target = rd_a.pred_target;
  assign a_have_exception     = rd_a.have_exc;
  assign a_exception_type     = rd_a.exc_type;

  assign b_valid              = (count >= (PTR_W+1)'(2));
  assign b_pc                 = rd_b.pc;
  assign b_inst               = rd_b.inst;
  assign b_pred_branch_taken  = rd_b.pred_taken;
  assign b_pred_branch_target = rd_b.pred_target;
  assign b_have_exception     = rd_b.have_exc;
  assign b_exception_type     = rd_b.exc_type;

`ifdef IQ_PERF_CNT_EN
  // Occupancy statistics; free-running, wrap naturally, immune to flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iq_empty_cycles <= '0;
      iq_stall_cycles <= '0;
    end else begin
      if (count == '0 && !flush) iq_empty_cycles <= iq_empty_cycles + 32'd1;
      if (!iq_ready)             iq_stall_cycles <= iq_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: scoreboard bench for inst_queue. The stimulus process models
// the queue as a plain FIFO of expected entries; the monitor compares the
// a/b slots and ready against that FIFO on every falling edge.
module tb_inst_queue;
  import iq_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  if_push_num = '0;
  logic [31:0] if0_pc = '0, if1_pc = '0, if0_inst = '0, if1_inst = '0;
  logic        if0_tk = 1'b0, if1_tk = 1'b0;
  logic [31:0] if0_tgt = '0, if1_tgt = '0;
  logic        if0_ex = 1'b0, if1_ex = 1'b0;
  exception_t  if0_et = '0, if1_et = '0;
  logic        iq_ready;
  logic [1:0]  id_consume_inst = '0;
  logic        a_valid, b_valid;
  logic [31:0] a_pc, a_inst, a_tgt, b_pc, b_inst, b_tgt;
  logic        a_tk, a_ex, b_tk, b_ex;
  exception_t  a_et, b_et;
`ifdef IQ_PERF_CNT_EN
  logic [31:0] iq_empty_cycles, iq_stall_cycles;
  int unsigned exp_empty = 0, exp_stall = 0;
`endif

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .if_push_num(if_push_num),
    .if0_pc(if0_pc), .if1_pc(if1_pc), .if0_inst(if0_inst), .if1_inst(if1_inst),
    .if0_pred_branch_taken(if0_tk), .if1_pred_branch_taken(if1_tk),
    .if0_pred_branch_target(if0_tgt), .if1_pred_branch_target(if1_tgt),
    .if0_have_exception(if0_ex), .if1_have_exception(if1_ex),
    .if0_exception_type(if0_et), .if1_exception_type(if1_et),
    .iq_ready(iq_ready), .id_consume_inst(id_consume_inst),
    .a_valid(a_valid), .a_pc(a_pc), .a_inst(a_inst), .a_pred_branch_taken(a_tk),
    .a_pred_branch_target(a_tgt), .a_have_exception(a_ex), .a_exception_type(a_et),
    .b_valid(b_valid), .b_pc(b_pc), .b_inst(b_inst), .b_pred_branch_taken(b_tk),
    .b_pred_branch_target(b_tgt), .b_have_exception(b_ex), .b_exception_type(b_et)
`ifdef IQ_PERF_CNT_EN
    , .iq_empty_cycles(iq_empty_cycles), .iq_stall_cycles(iq_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, inst, tgt;
    logic        tk, ex;
    exception_t  et;
  } ent_t;

  ent_t        exp_q[$];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] pc_ctr = 32'h1c00_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: DUT state after each rising edge vs the expected FIFO.
  always @(negedge clk) begin
    int sz;
    sz = exp_q.size();
    chk("a_valid", {63'd0, a_valid}, {63'd0, sz >= 1});
    chk("b_valid", {63'd0, b_valid}, {63'd0, sz >= 2});
    chk("iq_ready", {63'd0, iq_ready}, {63'd0, (DEPTH - sz) >= 2});
    if (sz >= 1) begin
      chk("a_pc", {32'd0, a_pc}, {32'd0, exp_q[0].pc});
      chk("a_inst", {32'd0, a_inst}, {32'd0, exp_q[0].inst});
      chk("a_tgt", {32'd0, a_tgt}, {32'd0, exp_q[0].tgt});
      chk("a_flags", {56'd0, a_tk, a_ex, a_et}, {56'd0, exp_q[0].tk, exp_q[0].ex, exp_q[0].et});
    end
    if (sz >= 2) begin
      chk("b_pc", {32'd0, b_pc}, {32'd0, exp_q[1].pc});
      chk("b_inst", {32'd0, b_inst}, {32'd0, exp_q[1].inst});
      chk("b_tgt", {32'd0, b_tgt}, {32'd0, exp_q[1].tgt});
      chk("b_flags", {56'd0, b_tk, b_ex, b_et}, {56'd0, exp_q[1].tk, exp_q[1].ex, exp_q[1].et});
    end
`ifdef IQ_PERF_CNT_EN
    chk("empty_cycles", {32'd0, iq_empty_cycles}, {32'd0, exp_empty});
    chk("stall_cycles", {32'd0, iq_stall_cycles}, {32'd0, exp_stall});
`endif
  end

  function automatic ent_t new_ent();
    ent_t e;
    e.pc   = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    e.inst = $urandom;
    e.tgt  = $urandom;
    e.tk   = 1'($urandom_range(0, 1));
    e.ex   = 1'($urandom_range(0, 1));
    e.et   = exception_t'($urandom_range(0, 63));
    return e;
  endfunction

  // Drive one cycle and fold its effect into the FIFO model, then move to
  // just after the next falling edge (monitor has checked by then).
  task automatic cycle(input int push, input int cons, input bit fl);
    ent_t e0, e1;
    bit   rdy;
    int   p;
    e0 = new_ent();
    e1 = new_ent();
    if_push_num = 2'(push);
    id_consume_inst = 2'(cons);
    flush = fl;
    if0_pc = e0.pc; if0_inst = e0.inst; if0_tgt = e0.tgt; if0_tk = e0.tk; if0_ex = e0.ex; if0_et = e0.et;
    if1_pc = e1.pc; if1_inst = e1.inst; if1_tgt = e1.tgt; if1_tk = e1.tk; if1_ex = e1.ex; if1_et = e1.et;
    rdy = (DEPTH - exp_q.size()) >= 2;
`ifdef IQ_PERF_CNT_EN
    if (exp_q.size() == 0 && !fl) exp_empty++;
    if (!rdy) exp_stall++;
`endif
    if (fl) begin
      exp_q.delete();
    end else begin
      p = (cons > exp_q.size()) ? exp_q.size() : cons;
      repeat (p) void'(exp_q.pop_front());
      if (rdy && push >= 1) exp_q.push_back(e0);
      if (rdy && push == 2) exp_q.push_back(e1);
    end
    // Sequential pcs only for entries that were really accepted.
    if (!(rdy && !fl)) pc_ctr = e0.pc;
    else if (push < 2) pc_ctr = e0.pc + 32'(push * 4);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_push_num = '0; id_consume_inst = '0; flush = 1'b0;
    reset = 1'b1;
    #1;
    exp_q.delete();
`ifdef IQ_PERF_CNT_EN
    exp_empty = 0; exp_stall = 0;
`endif
    chk("rst_a_valid", {63'd0, a_valid}, 64'd0);
    chk("rst_ready", {63'd0, iq_ready}, 64'd1);
    chk("rst_a_pc", {32'd0, a_pc}, 64'd0);
    chk("rst_b_pc", {32'd0, b_pc}, 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    cycle(0, 0, 0);
  endtask

  initial begin
    #2;
    do_reset();

    // Two pushes land in order.
    pc_ctr = 32'h1c00_0000;
    cycle(2, 0, 0);
    chk("dir_a_pc", {32'd0, a_pc}, 64'h1c00_0000);
    chk("dir_b_pc", {32'd0, b_pc}, 64'h1c00_0004);
    cycle(0, 2, 0);

    // Fill to full, try a dropped push, then drain with an over-consume.
    cycle(2, 0, 0); cycle(2, 0, 0); cycle(2, 0, 0);
    chk("fill3_ready", {63'd0, iq_ready}, 64'd1);
    cycle(2, 0, 0);
    chk("fill4_ready", {63'd0, iq_ready}, 64'd0);
    cycle(2, 0, 0);
    cycle(0, 2, 0);
    chk("drain_ready", {63'd0, iq_ready}, 64'd1);
    cycle(1, 0, 0);
    chk("seven_ready", {63'd0, iq_ready}, 64'd0);
    repeat (4) cycle(0, 2, 0);
    chk("drained_valid", {63'd0, a_valid}, 64'd0);

    // Steady dual push/pop across the pointer wrap.
    cycle(2, 0, 0);
    repeat (20) cycle(2, 2, 0);
    chk("wrap_b_valid", {63'd0, b_valid}, 64'd1);
    cycle(0, 2, 0);

    // Flush beats a same-cycle push and pop at count 5.
    cycle(2, 0, 0); cycle(2, 0, 0); cycle(1, 0, 0);
    cycle(2, 1, 1);
    chk("flush_a_valid", {63'd0, a_valid}, 64'd0);
    pc_ctr = 32'h0000_0200;
    cycle(2, 0, 0);
    chk("post_flush_a_pc", {32'd0, a_pc}, 64'h200);
    cycle(0, 2, 0);

    // Push 1 and pop 1 at count 1.
    cycle(1, 0, 0);
    pc_ctr = 32'h0000_0100;
    cycle(1, 1, 0);
    chk("p1c1_a_pc", {32'd0, a_pc}, 64'h100);
    chk("p1c1_b_valid", {63'd0, b_valid}, 64'd0);

    // Asynchronous reset mid-operation.
    cycle(2, 0, 0);
    do_reset();

`ifdef IQ_PERF_CNT_EN
    repeat (4) cycle(0, 0, 0);
    chk("perf_empty5", {32'd0, iq_empty_cycles}, 64'd5);
    cycle(0, 0, 1);
    chk("perf_flush_keep", {32'd0, iq_empty_cycles}, 64'd5);
`endif

    // Randomized traffic, including dropped pushes, clamped pops and flushes.
    repeat (3000) cycle($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 40) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
